// File: rtl/sr_tg_multi_if.sv
// UI bus between the traffic generator (master) and the memory controller (slave).
interface sr_tg_multi_if #(
   parameter int APP_DATA_WIDTH = 64,
   parameter int APP_ADDR_WIDTH = 33
);
   logic                        app_rdy;
   logic                        app_wdf_rdy;
   logic                        app_rd_data_valid;
   logic [APP_DATA_WIDTH-1:0]   app_rd_data;
   logic [2:0]                  app_cmd;
   logic [APP_ADDR_WIDTH-1:0]   app_addr;
   logic                        app_en;
   logic [APP_DATA_WIDTH-1:0]   app_wdf_data;
   logic                        app_wdf_wren;
   logic                        app_wdf_end;
   logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask;

   modport master (
      input  app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data,
      output app_cmd, app_addr, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask
   );

   modport slave (
      output app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data,
      input  app_cmd, app_addr, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask
   );
endinterface

// File: rtl/sr_tg_multi.sv
// Write-then-read traffic generator for the DDR UI, either feeding data through the
// SR block (SR mode) or writing and checking a seed/index pattern (PATTERN mode).
module sr_tg_multi #(
   parameter int APP_DATA_WIDTH = 64,
   parameter int APP_ADDR_WIDTH = 33,
   parameter int ADDR_STEP      = 8,
   parameter int CNT_WIDTH      = 16,
   parameter int GAP_CYCLES     = 45
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      init_calib_complete,
   input  logic                      start,
   input  logic                      mode,
   input  logic [APP_ADDR_WIDTH-1:0] base_addr,
   input  logic [CNT_WIDTH-1:0]      num_words,
   input  logic [31:0]               seed,
   output logic [APP_DATA_WIDTH-1:0] sr_din,
   output logic                      sr_newd,
   input  logic                      sr_done,
   input  logic [APP_DATA_WIDTH-1:0] sr_dout,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic [CNT_WIDTH-1:0]      err_count,
   output logic [CNT_WIDTH-1:0]      rd_count,
   sr_tg_multi_if.master             ui
);
   localparam int WORDS = APP_DATA_WIDTH / 32;
   localparam int GW    = $clog2(GAP_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, WCAL, WFETCH, WISSUE, GAP, RISSUE, DRAIN, FIN} state_t;

   state_t                    state_r;
   logic                      mode_r;
   logic [APP_ADDR_WIDTH-1:0] base_r;
   logic [CNT_WIDTH-1:0]      nwords_r;
   logic [31:0]               seed_r;
   logic [CNT_WIDTH-1:0]      idx_r;
   logic [GW-1:0]             gap_cnt_r;
   logic [GW-1:0]             idle_cnt_r;
   logic                      timeout_r;
   logic                      fetch_sent_r;

   logic [CNT_WIDTH-1:0]      idx_nxt_s;
   logic                      cmd_fire_s;
   logic                      data_fire_s;
   logic                      wr_both_s;
   logic                      cap_en_s;
   logic                      beat_err_s;

   function automatic logic [APP_DATA_WIDTH-1:0] pattern_f(input logic [31:0] s,
                                                          input logic [CNT_WIDTH-1:0] i);
      logic [31:0] w;
      w = s ^ 32'(i);
      return {WORDS{w}};
   endfunction

   function automatic logic [APP_ADDR_WIDTH-1:0] addr_f(input logic [APP_ADDR_WIDTH-1:0] b,
                                                       input logic [CNT_WIDTH-1:0] i);
      return b + APP_ADDR_WIDTH'(i) * APP_ADDR_WIDTH'(ADDR_STEP);
   endfunction

   assign idx_nxt_s   = idx_r + CNT_WIDTH'(1'b1);
   assign cmd_fire_s  = ui.app_en & ui.app_rdy;
   assign data_fire_s = ui.app_wdf_wren & ui.app_wdf_rdy;
   // A write beat is finished once neither the command nor the data is still outstanding.
   assign wr_both_s   = (~ui.app_en | ui.app_rdy) & (~ui.app_wdf_wren | ui.app_wdf_rdy);
   assign cap_en_s    = (state_r != IDLE) && (state_r != WCAL);

   assign ui.app_wdf_end  = ui.app_wdf_wren;
   assign ui.app_wdf_mask = {(APP_DATA_WIDTH/8){1'b0}};

   // Classify the incoming read beat: overflow beats always count, PATTERN mode also compares.
   always_comb begin
      beat_err_s = 1'b0;
      if (rd_count >= nwords_r) begin
         beat_err_s = 1'b1;
      end else if (mode_r) begin
         beat_err_s = (ui.app_rd_data != pattern_f(seed_r, rd_count));
      end else begin
         beat_err_s = 1'b0;
      end
   end

   // Run sequencer plus read-beat accounting; all status and UI outputs are registered here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r         <= IDLE;
         mode_r          <= 1'b0;
         base_r          <= {APP_ADDR_WIDTH{1'b0}};
         nwords_r        <= {CNT_WIDTH{1'b0}};
         seed_r          <= 32'h0000_0000;
         idx_r           <= {CNT_WIDTH{1'b0}};
         gap_cnt_r       <= {GW{1'b0}};
         idle_cnt_r      <= {GW{1'b0}};
         timeout_r       <= 1'b0;
         fetch_sent_r    <= 1'b0;
         sr_din          <= {APP_DATA_WIDTH{1'b0}};
         sr_newd         <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         err_count       <= {CNT_WIDTH{1'b0}};
         rd_count        <= {CNT_WIDTH{1'b0}};
         ui.app_cmd      <= 3'd1;
         ui.app_addr     <= {APP_ADDR_WIDTH{1'b0}};
         ui.app_en       <= 1'b0;
         ui.app_wdf_data <= {APP_DATA_WIDTH{1'b0}};
         ui.app_wdf_wren <= 1'b0;
      end else begin
         sr_newd <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  mode_r    <= mode;
                  base_r    <= base_addr;
                  nwords_r  <= (num_words == {CNT_WIDTH{1'b0}}) ? CNT_WIDTH'(1'b1) : num_words;
                  seed_r    <= seed;
                  idx_r     <= {CNT_WIDTH{1'b0}};
                  err_count <= {CNT_WIDTH{1'b0}};
                  rd_count  <= {CNT_WIDTH{1'b0}};
                  timeout_r <= 1'b0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  state_r   <= WCAL;
               end
            end
            WCAL: begin
               if (init_calib_complete) begin
                  fetch_sent_r <= 1'b0;
                  state_r      <= WFETCH;
               end
            end
            WFETCH: begin
               if (init_calib_complete && (mode_r || (fetch_sent_r && sr_done))) begin
                  ui.app_en       <= 1'b1;
                  ui.app_cmd      <= 3'd0;
                  ui.app_addr     <= addr_f(base_r, idx_r);
                  ui.app_wdf_data <= mode_r ? pattern_f(seed_r, idx_r) : sr_dout;
                  ui.app_wdf_wren <= 1'b1;
                  state_r         <= WISSUE;
               end else if (init_calib_complete && !fetch_sent_r) begin
                  sr_din       <= pattern_f(seed_r, idx_r);
                  sr_newd      <= 1'b1;
                  fetch_sent_r <= 1'b1;
               end
            end
            WISSUE: begin
               if (cmd_fire_s) begin
                  ui.app_en <= 1'b0;
               end
               if (data_fire_s) begin
                  ui.app_wdf_wren <= 1'b0;
               end
               if (wr_both_s) begin
                  idx_r        <= idx_nxt_s;
                  fetch_sent_r <= 1'b0;
                  if (idx_nxt_s == nwords_r) begin
                     gap_cnt_r <= {GW{1'b0}};
                     state_r   <= GAP;
                  end else begin
                     state_r   <= WFETCH;
                  end
               end
            end
            GAP: begin
               if (gap_cnt_r == GW'(GAP_CYCLES - 1)) begin
                  idx_r       <= {CNT_WIDTH{1'b0}};
                  ui.app_en   <= init_calib_complete;
                  ui.app_cmd  <= 3'd1;
                  ui.app_addr <= base_r;
                  state_r     <= RISSUE;
               end else begin
                  gap_cnt_r <= gap_cnt_r + GW'(1'b1);
               end
            end
            RISSUE: begin
               // Commands stream back-to-back; a calibration loss pauses after the accepted one.
               if (cmd_fire_s) begin
                  idx_r       <= idx_nxt_s;
                  ui.app_addr <= addr_f(base_r, idx_nxt_s);
                  if (idx_nxt_s == nwords_r) begin
                     ui.app_en  <= 1'b0;
                     idle_cnt_r <= {GW{1'b0}};
                     state_r    <= DRAIN;
                  end else begin
                     ui.app_en <= init_calib_complete;
                  end
               end else if (!ui.app_en && init_calib_complete) begin
                  ui.app_en <= 1'b1;
               end
            end
            DRAIN: begin
               if (rd_count >= nwords_r) begin
                  state_r <= FIN;
               end else if (ui.app_rd_data_valid) begin
                  idle_cnt_r <= {GW{1'b0}};
               end else if (idle_cnt_r == GW'(GAP_CYCLES - 1)) begin
                  timeout_r <= 1'b1;
                  state_r   <= FIN;
               end else begin
                  idle_cnt_r <= idle_cnt_r + GW'(1'b1);
               end
            end
            FIN: begin
               busy    <= 1'b0;
               done    <= 1'b1;
               pass    <= !timeout_r && (err_count == {CNT_WIDTH{1'b0}}) && (rd_count == nwords_r);
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase

         if (cap_en_s && ui.app_rd_data_valid) begin
            rd_count <= rd_count + CNT_WIDTH'(1'b1);
            if (beat_err_s && (err_count != {CNT_WIDTH{1'b1}})) begin
               err_count <= err_count + CNT_WIDTH'(1'b1);
            end
            if (!mode_r) begin
               sr_din  <= ui.app_rd_data;
               sr_newd <= 1'b1;
            end
         end
      end
   end
endmodule

// File: doc/sr_tg_multi.md
Name: sr_tg_multi

Overview:
Parametrised successor to the single-pass shift-register traffic generator between the DDR memory-controller UI and the shift-register (SR) datapath. It runs a programmable-length write pass, then a read-back pass, in one of two modes. SR mode routes write data through the SR block. PATTERN mode writes an address/seed pattern and checks it on read-back. It adds a start/done handshake, held-until-accepted UI commands, read-beat accounting, a drain timeout and an error count.

Parameters:
APP_DATA_WIDTH, 64, UI data width; multiple of 32.
APP_ADDR_WIDTH, 33, UI address width.
ADDR_STEP, 8, address increment per beat.
CNT_WIDTH, 16, width of num_words and beat counters.
GAP_CYCLES, 45, idle cycles between write and read passes; also the drain timeout.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
init_calib_complete  in  1  memory calibration done
start  in  1  one-cycle pulse; begins a run when in IDLE
mode  in  1  0=SR mode, 1=PATTERN mode; sampled at start
base_addr  in  APP_ADDR_WIDTH  first beat address; sampled at start
num_words  in  CNT_WIDTH  beats per pass; sampled at start; 0 is treated as 1
seed  in  32  pattern seed; sampled at start
sr_din  out  APP_DATA_WIDTH  data to SR block
sr_newd  out  1  one-cycle strobe: sr_din valid
sr_done  in  1  SR block has sr_dout valid
sr_dout  in  APP_DATA_WIDTH  SR block result
app_rdy, app_wdf_rdy, app_rd_data_valid  in  1  UI handshakes
app_rd_data  in  APP_DATA_WIDTH  UI read data
app_cmd  out  3  0=write, 1=read
app_addr  out  APP_ADDR_WIDTH  UI address
app_en  out  1  command valid
app_wdf_data  out  APP_DATA_WIDTH  write data
app_wdf_wren, app_wdf_end  out  1  write data valid; end equals wren
app_wdf_mask  out  APP_DATA_WIDTH/8  tied to 0
busy, done, pass  out  1  run status
err_count  out  CNT_WIDTH  PATTERN-mode miscompares; saturates at all-ones
rd_count  out  CNT_WIDTH  read beats received in the current run

Behaviour:
- Reset (rst=0, async) forces all outputs to 0, except app_cmd=1. All counters are cleared. The FSM goes to IDLE.
- pattern(i) = {APP_DATA_WIDTH/32 copies of (seed XOR i)}, where i is the 32-bit zero-extended beat index.
- FSM states: IDLE, WCAL, WFETCH, WISSUE, GAP, RISSUE, DRAIN, FIN.
- IDLE:
  - start=1 latches the inputs, clears counters, sets busy=1, done=0, pass=0, and moves to WCAL.
  - start is ignored in every other state.
- WCAL: wait for init_calib_complete=1, then go to WFETCH.
- WFETCH:
  - SR mode: drive sr_din=pattern(i) and pulse sr_newd for 1 cycle. Wait for sr_done=1, capture sr_dout as the write word, go to WISSUE.
  - PATTERN mode: the write word is pattern(i); go to WISSUE the next cycle.
- WISSUE:
  - Assert app_en=1, app_cmd=0, app_addr=base_addr+i*ADDR_STEP, app_wdf_wren=app_wdf_end=1.
  - app_en drops on the first cycle app_rdy=1. app_wdf_wren drops on the first cycle app_wdf_rdy=1. Both may complete in the same cycle, in either order.
  - When both have completed, i increments. If i reaches num_words, go to GAP; otherwise go to WFETCH.
- GAP: hold all strobes low for exactly GAP_CYCLES cycles, then reset i=0 and go to RISSUE.
- RISSUE:
  - Assert app_en=1, app_cmd=1, app_addr=base_addr+i*ADDR_STEP.
  - On each app_rdy=1 cycle, i increments. app_en stays high back-to-back until i reaches num_words, then drops and the FSM goes to DRAIN.
- Read-data capture (any state after WCAL):
  - Each app_rd_data_valid beat increments rd_count, with beats numbered in order j=0,1,...
  - SR mode: sr_din=app_rd_data and sr_newd pulses for that cycle.
  - PATTERN mode: compare the beat against pattern(j); a mismatch increments err_count.
  - Beats beyond num_words still increment rd_count and count as an error in both modes.
- DRAIN:
  - Wait until rd_count reaches num_words, then go to FIN.
  - If GAP_CYCLES consecutive cycles pass with no app_rd_data_valid, go to FIN with a timeout flag set.
- FIN: busy=0 and done=1; both hold until the next start.
  - pass=1 iff no timeout, err_count=0 and rd_count=num_words.
- If init_calib_complete falls mid-run, the FSM finishes the current UI handshake, then holds in place without asserting app_en until calibration returns.
- Address arithmetic wraps modulo 2^APP_ADDR_WIDTH.
- All outputs are registered except app_wdf_end, which is a wire copy of app_wdf_wren.

Test Plan:
1. PATTERN mode, num_words=4, base_addr=0x100, seed=0xA5A5A5A5, app_rdy=app_wdf_rdy=1, a memory model echoes writes -> 4 writes at 0x100/108/110/118 carrying pattern(0..3), then 4 reads; done=1, pass=1, err_count=0, rd_count=4.
2. Same as 1, but the model corrupts bit 0 of beat 2 -> err_count=1, pass=0.
3. SR mode, num_words=3, SR model returns sr_done 5 cycles after sr_newd with sr_dout=~sr_din -> each written word equals ~pattern(i); each read beat appears on sr_din with an sr_newd pulse.
4. Backpressure: app_rdy low for 3 cycles and app_wdf_rdy low for 5 cycles on beat 0 -> app_en and app_wdf_wren held stable until each accepts; exactly num_words writes are issued.
5. Model drops the last read beat -> FIN after GAP_CYCLES idle cycles in DRAIN; pass=0, rd_count=num_words-1.
6. rst asserted mid-RISSUE, then released and start pulsed -> all outputs 0 and app_cmd=1 immediately on reset; the rerun passes cleanly; num_words=0 runs exactly 1 beat.
